// File: rtl/line_buf_pkg.sv
// Shared definitions for the line buffer read-side scheduler.
//   state_t       : scheduler FSM states
//   FILL_VAL_DEF  : default pixel substituted on FIFO underrun
//   clog2()       : ceiling log2, used when sizing pixel counters
package line_buf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        ACTIVE = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] FILL_VAL_DEF = 8'h00;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_buf_rd_sched.sv
// Read-side scheduler for the asynchronous pixel line FIFO (rd_clk domain).
// Reads one FIFO word per display data-enable cycle, emits exactly H_ACTIVE
// pixels per line, substitutes FILL_VAL on underrun and realigns the FIFO
// by flushing the unread remainder of a short line.
//
// Ports:
//   rd_clk, rd_rst          clock, async active-high reset
//   enable                  scheduler enable, acted on at line boundaries
//   clr_err                 pulse: clears err_short and underrun_cnt
//   vid_de                  display data-enable
//   fifo_rd_en              FIFO read strobe (combinational)
//   fifo_rd_data            FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty              FIFO empty flag
//   fifo_almost_empty       FIFO almost-empty flag (early warning at line start)
//   pix_out, pix_vld        registered output pixel, two cycles after vid_de
//   line_done               one-cycle pulse per scheduled line
//   busy                    high outside IDLE
//   err_short               sticky: vid_de ended before H_ACTIVE pixels
//   underrun_cnt            saturating underrun pixel count
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | scheduler disabled, no reads
// ARMED  | waiting for the first vid_de of a line (that cycle is pixel 0)
// ACTIVE | reading one word per vid_de cycle, cnt = current pixel index
// FLUSH  | discarding the rest of a short line, cnt = words still owed
// DONE   | single cycle, line_done pulses
module line_buf_rd_sched
    import line_buf_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                H_ACTIVE = 1024,
    parameter int                CNT_W    = 12,
    parameter logic [DATA_W-1:0] FILL_VAL = DATA_W'(FILL_VAL_DEF)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    input  logic              clr_err,
    input  logic              vid_de,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_almost_empty,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_vld,
    output logic              line_done,
    output logic              busy,
    output logic              err_short,
    output logic [15:0]       underrun_cnt
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(H_ACTIVE);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pipe_vld;
    logic             pipe_und;

    logic             start_px;
    logic             pix_cyc;
    logic             flush_lost;
    logic             ae_hit;
    logic [1:0]       und_inc;
    logic [16:0]      und_sum;
    logic [15:0]      und_next;

    always_comb begin
        start_px   = (state == ARMED) && enable && vid_de;
        pix_cyc    = start_px || ((state == ACTIVE) && vid_de);
        // a new line arriving during FLUSH has no slot; its pixels are lost
        flush_lost = (state == FLUSH) && vid_de;
        ae_hit     = start_px && fifo_almost_empty;
        fifo_rd_en = !fifo_empty && (pix_cyc || (state == FLUSH));
        und_inc    = 2'(pix_cyc && fifo_empty) + 2'(ae_hit) + 2'(flush_lost);
        und_sum    = {1'b0, underrun_cnt} + 17'(und_inc);
        und_next   = und_sum[16] ? 16'hFFFF : und_sum[15:0];
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            line_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vid_de) begin
                        cnt <= CNT_W'(1);
                        if (LAST_PIX == '0) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end else begin
                            state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (vid_de) begin
                        if (cnt == LAST_PIX) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // counter switches meaning: pixels owed to realign the FIFO
                        state <= FLUSH;
                        cnt   <= LINE_LEN - cnt;
                    end
                end
                FLUSH: begin
                    if (!fifo_empty) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (enable) begin
                        state <= ARMED;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // clear has priority over a same-cycle set or increment
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            err_short    <= 1'b0;
            underrun_cnt <= '0;
        end else if (clr_err) begin
            err_short    <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if ((state == ACTIVE) && !vid_de)
                err_short <= 1'b1;
            underrun_cnt <= und_next;
        end
    end

    // FIFO data lands one cycle after the read, so valid/underrun ride a
    // one-stage pipe to meet it at the output register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pipe_vld <= 1'b0;
            pipe_und <= 1'b0;
            pix_vld  <= 1'b0;
            pix_out  <= '0;
        end else begin
            pipe_vld <= pix_cyc;
            pipe_und <= fifo_empty;
            pix_vld  <= pipe_vld;
            if (pipe_vld)
                pix_out <= pipe_und ? FILL_VAL : fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_line_buf_rd_sched.sv
module tb_line_buf_rd_sched;

    localparam int         H    = 1024;
    localparam logic [7:0] FILL = 8'h00;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        enable;
    logic        clr_err;
    logic        vid_de;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_almost_empty;
    logic [7:0]  pix_out;
    logic        pix_vld;
    logic        line_done;
    logic        busy;
    logic        err_short;
    logic [15:0] underrun_cnt;

    always #5 rd_clk = ~rd_clk;

    line_buf_rd_sched #(
        .DATA_W  (8),
        .H_ACTIVE(H),
        .CNT_W   (12),
        .FILL_VAL(FILL)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rst           (rd_rst),
        .enable           (enable),
        .clr_err          (clr_err),
        .vid_de           (vid_de),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_empty       (fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .pix_out          (pix_out),
        .pix_vld          (pix_vld),
        .line_done        (line_done),
        .busy             (busy),
        .err_short        (err_short),
        .underrun_cnt     (underrun_cnt)
    );

    typedef struct {
        int preload;
        int de_len;
        int toggle;
        int ae;
        int drop_en;
        int exp_vld;
        int exp_und;
        int exp_err;
        int exp_left;
        int exp_busy;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    logic [7:0] exp_px[$];
    int         vld_cnt = 0;
    int         ld_cnt = 0;
    int         first_vld = -1;
    logic       busy_s = 1'b0;
    logic       rd_en_s = 1'b0;
    bit         force_empty = 0;
    bit         mon_en = 0;
    int         wseq = 0;
    int         und_tot = 0;
    int         err_model = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge rd_clk) cyc++;

    // scoreboard: every valid pixel must match the next expected one in order
    always @(negedge rd_clk) begin
        rd_en_s = fifo_rd_en;
        busy_s  = busy;
        if (mon_en) begin
            if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 0);
            if (line_done) ld_cnt++;
            if (pix_vld) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                if (exp_px.size() == 0) chk("pix_unexpected", pix_vld, 0);
                else chk("pix_data", pix_out, exp_px.pop_front());
            end
        end
    end

    task automatic drive_empty();
        fifo_empty = force_empty || (q.size() == 0);
    endtask

    // one clock: inputs already set at posedge+1; FIFO pops after the edge
    task automatic step();
        @(negedge rd_clk);
        @(posedge rd_clk);
        #1;
        if (rd_en_s && q.size() > 0) fifo_rd_data = q.pop_front();
    endtask

    task automatic add_words(input int n);
        for (int k = 0; k < n; k++) begin
            q.push_back(8'(wseq));
            wseq++;
        end
    endtask

    task automatic run_line(input int preload, input int de_len, input int toggle,
                            input int ae, input int drop_en,
                            output int m_vld, output int m_ld, output int m_lat,
                            output int m_left, output int m_busy,
                            output int und_d, output int exp_left);
        int vld0, ld0, start_sz, reads, de_cyc;
        bit seen;
        add_words(preload);
        enable = 1; vid_de = 0; fifo_almost_empty = 0; force_empty = 0;
        repeat (2) begin drive_empty(); step(); end
        start_sz = q.size(); vld0 = vld_cnt; ld0 = ld_cnt; first_vld = -1;
        reads = 0; und_d = (ae != 0) ? 1 : 0; de_cyc = cyc;
        for (int i = 0; i < de_len; i++) begin
            vid_de = 1;
            fifo_almost_empty = (ae != 0);
            force_empty = (toggle != 0) && (i % 2 == 1);
            if (i == drop_en) enable = 0;
            drive_empty();
            if (fifo_empty) begin
                exp_px.push_back(FILL);
                und_d++;
            end else begin
                exp_px.push_back(q[0]);
                reads++;
            end
            step();
        end
        vid_de = 0; fifo_almost_empty = 0; force_empty = 0;
        seen = 0;
        for (int k = 0; k < H + 40 && !seen; k++) begin
            drive_empty();
            step();
            if (ld_cnt != ld0) seen = 1;
        end
        chk("line_done_seen", seen, 1);
        drive_empty(); step();
        m_busy = busy_s;
        drive_empty(); step();
        m_vld    = vld_cnt - vld0;
        m_ld     = ld_cnt - ld0;
        m_lat    = first_vld - de_cyc;
        m_left   = q.size();
        exp_left = start_sz - reads - ((de_len < H) ? (H - de_len) : 0);
    endtask

    initial begin
        vec_t tbl[7];
        int m_vld, m_ld, m_lat, m_left, m_busy, und_d, exp_left;
        int ld0, vld0;

        //            pre   de   tog ae drop  vld  und err left busy
        tbl[0] = '{1024, 1024, 0, 0, -1, 1024,   0, 0,   0, 1};
        tbl[1] = '{1000, 1024, 0, 0, -1, 1024,  24, 0,   0, 1};
        tbl[2] = '{1024, 1024, 1, 0, -1, 1024, 512, 0, 512, 1};
        tbl[3] = '{ 512, 1024, 0, 1, -1, 1024,   1, 0,   0, 1};
        tbl[4] = '{1024, 1024, 0, 0, 100, 1024,  0, 0,   0, 0};
        tbl[5] = '{ 950, 1024, 0, 0, -1, 1024,  74, 0,   0, 1};
        tbl[6] = '{1024,  600, 0, 0, -1,  600,   0, 1,   0, 1};

        rd_rst = 1; enable = 1; vid_de = 1; clr_err = 0;
        fifo_almost_empty = 0; fifo_empty = 0; fifo_rd_data = 8'h00;
        #12;
        chk("rst_pix_vld", pix_vld, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        vid_de = 0;
        @(posedge rd_clk); #1;
        rd_rst = 0;
        mon_en = 1;

        for (int r = 0; r < 7; r++) begin
            run_line(tbl[r].preload, tbl[r].de_len, tbl[r].toggle, tbl[r].ae, tbl[r].drop_en,
                     m_vld, m_ld, m_lat, m_left, m_busy, und_d, exp_left);
            und_tot += tbl[r].exp_und;
            chk($sformatf("row%0d_vld", r), m_vld, tbl[r].exp_vld);
            chk($sformatf("row%0d_line_done", r), m_ld, 1);
            chk($sformatf("row%0d_latency", r), m_lat, 2);
            chk($sformatf("row%0d_underrun", r), underrun_cnt, und_tot);
            chk($sformatf("row%0d_err_short", r), err_short, tbl[r].exp_err);
            chk($sformatf("row%0d_fifo_left", r), m_left, tbl[r].exp_left);
            chk($sformatf("row%0d_busy_after", r), m_busy, tbl[r].exp_busy);
        end
        err_model = 1;

        clr_err = 1; drive_empty(); step();
        clr_err = 0;
        chk("clr_err_short", err_short, 0);
        chk("clr_err_underrun", underrun_cnt, 0);
        und_tot = 0; err_model = 0;

        for (int r = 0; r < 6; r++) begin
            int pre, de, tog, ae;
            bit short_line;
            short_line = ($urandom_range(0, 2) == 0);
            ae = $urandom_range(0, 1);
            if (short_line) begin
                de = $urandom_range(1, H - 1);
                pre = H + $urandom_range(0, 50);
                tog = 0;
            end else begin
                de = H;
                pre = $urandom_range(900, 1100);
                tog = $urandom_range(0, 1);
            end
            run_line(pre, de, tog, ae, -1, m_vld, m_ld, m_lat, m_left, m_busy, und_d, exp_left);
            und_tot += und_d;
            if (short_line) err_model = 1;
            chk($sformatf("rnd%0d_vld", r), m_vld, de);
            chk($sformatf("rnd%0d_line_done", r), m_ld, 1);
            chk($sformatf("rnd%0d_latency", r), m_lat, 2);
            chk($sformatf("rnd%0d_underrun", r), underrun_cnt, und_tot);
            chk($sformatf("rnd%0d_err_short", r), err_short, err_model);
            chk($sformatf("rnd%0d_fifo_left", r), m_left, exp_left);
            chk($sformatf("rnd%0d_busy_after", r), m_busy, 1);
        end

        // reset in the middle of a line
        add_words(1024);
        enable = 1; vid_de = 0;
        repeat (2) begin drive_empty(); step(); end
        for (int i = 0; i < 500; i++) begin
            vid_de = 1;
            drive_empty();
            exp_px.push_back(fifo_empty ? FILL : q[0]);
            step();
        end
        ld0 = ld_cnt;
        rd_rst = 1;
        exp_px.delete();
        #1;
        chk("midrst_pix_vld", pix_vld, 0);
        chk("midrst_pix_out", pix_out, 0);
        chk("midrst_line_done", line_done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err_short", err_short, 0);
        chk("midrst_underrun", underrun_cnt, 0);
        chk("midrst_rd_en", fifo_rd_en, 0);
        q.delete();
        vld0 = vld_cnt;
        vid_de = 0;
        repeat (2) begin drive_empty(); step(); end
        rd_rst = 0; enable = 0;
        repeat (10) begin drive_empty(); step(); end
        chk("midrst_no_line_done", ld_cnt - ld0, 0);
        chk("midrst_no_pix_vld", vld_cnt - vld0, 0);
        chk("midrst_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_buf_rd_sched.md
# line_buf_rd_sched

Read-side scheduler for the asynchronous pixel line FIFO in the video path. It runs in the `rd_clk` domain and sequences FIFO reads against the display timing generator's data-enable. It guarantees exactly `H_ACTIVE` pixels per line and substitutes a fill value on underrun. It also realigns the FIFO after short lines and reports errors to the control plane.

## Interface
- `DATA_W`, 8: pixel width; equals the FIFO read data width.
- `H_ACTIVE`, 1024: active pixels per line.
- `CNT_W`, 12: pixel counter width; must satisfy 2^CNT_W ≥ H_ACTIVE.
- `FILL_VAL`, 8'h00: pixel emitted on underrun.
- `rd_clk`  in  1  read clock.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scheduler enable; sampled only at line boundaries.
- `clr_err`  in  1  single-cycle pulse; clears `err_short` and `underrun_cnt`.
- `vid_de`  in  1  display data-enable from the timing generator.
- `fifo_rd_en`  out  1  FIFO read enable; combinational.
- `fifo_rd_data`  in  DATA_W  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_almost_empty`  in  1  FIFO almost-empty flag.
- `pix_out`  out  DATA_W  output pixel; registered.
- `pix_vld`  out  1  output pixel valid; registered.
- `line_done`  out  1  one-cycle pulse at the end of each scheduled line.
- `busy`  out  1  high in any state except IDLE.
- `err_short`  out  1  sticky flag: `vid_de` fell before `H_ACTIVE` pixels.
- `underrun_cnt`  out  16  saturating count of underrun pixels.

## Operation
- FSM states and transitions:
  - IDLE → ARMED when `enable`=1.
  - ARMED → IDLE when `enable`=0.
  - ARMED → ACTIVE on the first cycle with `vid_de`=1. That cycle counts as pixel 0.
  - ACTIVE → DONE when the pixel counter reaches `H_ACTIVE`-1 with `vid_de`=1.
  - ACTIVE → FLUSH when `vid_de`=0 before the last pixel.
  - FLUSH → DONE when the remaining count reaches 0.
  - DONE lasts one cycle, pulses `line_done`, then goes to ARMED if `enable`=1, else IDLE.
- ARMED and ACTIVE with `vid_de`=1:
  - `fifo_rd_en` = !`fifo_empty`.
  - If `fifo_empty`=1, the pixel is an underrun: emit `FILL_VAL` and increment `underrun_cnt` (saturates at 16'hFFFF).
  - The pixel counter increments every `vid_de` cycle regardless of underrun.
- FLUSH:
  - Sets `err_short` on entry.
  - Reads the remaining `H_ACTIVE`-count words with `fifo_rd_en` = !`fifo_empty`.
  - Discards the data; `pix_vld` stays 0.
  - Stalls while `fifo_empty`=1. Each word read decrements the remaining count, so the next line starts aligned.
  - `vid_de` is ignored in FLUSH. Pixels of a line starting during FLUSH are lost and counted as underruns.
- `fifo_almost_empty` at the ARMED→ACTIVE transition increments `underrun_cnt` by one extra (early-warning count); no other effect.
- `enable` deasserted mid-line: the current line completes (ACTIVE/FLUSH/DONE), then the FSM goes to IDLE.
- `clr_err` coinciding with an increment or a FLUSH entry: the clear wins for that cycle.

## Timing
- Reset values:
  - `pix_out`=0, `pix_vld`=0, `line_done`=0, `busy`=0, `err_short`=0, `underrun_cnt`=0.
  - State is IDLE, so `fifo_rd_en`=0.
- Latency: a `vid_de` cycle n produces `pix_vld`=1 at cycle n+2. Data comes from `fifo_rd_data` (sampled at n+1) or is `FILL_VAL`.
- `line_done` is asserted in the cycle after the last read or flush cycle.
- `fifo_rd_en` is never asserted while `fifo_empty`=1 or in IDLE/DONE.
- `rd_rst` mid-line: everything returns to IDLE immediately. The in-flight pixel is dropped; no `pix_vld` or `line_done` follows.
- `pix_vld`=1 occurs exactly `H_ACTIVE` times per line for every full-length `vid_de` window.

## Structure
- Package `line_buf_pkg`:
  - FSM state enum (IDLE, ARMED, ACTIVE, FLUSH, DONE).
  - Default `FILL_VAL`.
  - Counter width function clog2.
- Single module, no sub-modules:
  - FSM;
  - pixel/remaining counter (shared, CNT_W bits);
  - one-stage underrun/valid delay pipe;
  - output register;
  - saturating error counter.

## Test plan
- Full line, FIFO preloaded with 1024 words 0..255 repeating; `vid_de` high 1024 cycles → 1024 `pix_vld` pulses, data matches in order, `line_done` pulses once, `underrun_cnt`=0.
- FIFO holds 1000 words, full 1024-cycle line → last 24 pixels = 8'h00, `underrun_cnt`=24, next line starts aligned.
- `vid_de` drops after 600 pixels, FIFO holds 1024 words → `err_short`=1, 424 words flushed with no `pix_vld`, FIFO empty, `line_done` pulses; `clr_err` then clears the flag.
- `enable` dropped at pixel 100 → line completes 1024 pixels, `line_done` pulses, `busy`=0 one cycle later.
- `rd_rst` asserted at pixel 500 → all outputs 0 the same cycle, `fifo_rd_en`=0, no `line_done`.
- `fifo_empty` toggled every other cycle during a line → `fifo_rd_en` never high while empty, `underrun_cnt` equals the number of empty cycles.
